// File: rtl/round_robin_arbiter_8.sv
// Round-robin arbiter for one 8-way select resource with hold/release ownership.
// Optional grant timeout is compiled in when ARB_TIMEOUT_EN is defined (limit MAX_HOLD).
module round_robin_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic       grant_valid,
  output logic [2:0] grant_code,
  output logic [7:0] grant_onehot,
  output logic       timeout_pulse
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nx;
  logic [2:0] last, last_nx;
  logic [7:0] cnt, cnt_nx;
  logic [2:0] code_nx;
  logic       valid_nx;
  logic       tp_nx;
  logic [7:0] onehot_nx;
  logic [2:0] winner;
  logic       found;
  logic       timeout;

  // Code i drives one-hot bit 7-i.
  function automatic logic [7:0] dec3to8(input logic [2:0] code);
    logic [7:0] v;
    v = '0;
    v[3'd7 - code] = 1'b1;
    return v;
  endfunction

  // Search starts just after the previous owner and wraps modulo 8.
  always_comb begin
    logic [2:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  assign timeout = (cnt == 8'(MAX_HOLD));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    valid_nx = grant_valid;
    code_nx  = grant_code;
    cnt_nx   = cnt;
    last_nx  = last;
    tp_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          valid_nx = 1'b1;
          code_nx  = winner;
          cnt_nx   = 8'd1;
        end
      end
      GRANT: begin
        if (!req[grant_code] || timeout) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
          code_nx  = 3'd0;
          cnt_nx   = 8'd0;
          last_nx  = grant_code;
          // Only a revoke can release while the owner still requests.
          tp_nx    = req[grant_code];
        end else if (cnt != 8'hFF) begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    onehot_nx = valid_nx ? dec3to8(code_nx) : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant_valid   <= 1'b0;
      grant_code    <= 3'd0;
      grant_onehot  <= 8'h00;
      timeout_pulse <= 1'b0;
      last          <= 3'd7;
      cnt           <= 8'd0;
    end else begin
      state         <= state_nx;
      grant_valid   <= valid_nx;
      grant_code    <= code_nx;
      grant_onehot  <= onehot_nx;
      timeout_pulse <= tp_nx;
      last          <= last_nx;
      cnt           <= cnt_nx;
    end
  end

endmodule
